// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: EX/MEM and MEM/WB pipeline registers plus data-memory access FSM
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   ex_*                        instruction leaving the execute stage
//   flush_ex                    squash the instruction entering EX/MEM
//   dmem_req/we/addr/wdata      data-memory request, held stable until dmem_ack
//   dmem_ack, dmem_rdata        completion and same-cycle load data
//   EX_MEM_*                    EX/MEM stage contents for forwarding
//   MEM_WB_rd/RegWrite, wb_data writeback destination, enable and value
//   mem_stall                   freeze IF/ID/EX while a memory op awaits dmem_ack
//   stall_cnt                   saturating count of stall cycles
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              flush_ex,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  input  logic [1:0]        ex_write_src,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [DATA_W-1:0] ex_imm_op,
  input  logic [DATA_W-1:0] ex_pc_plus4,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [4:0]        EX_MEM_rd,
  output logic              EX_MEM_RegWrite,
  output logic [1:0]        EX_MEM_WriteSrc,
  output logic [DATA_W-1:0] EX_MEM_AluOut,
  output logic [DATA_W-1:0] EX_MEM_ImmOp,
  output logic [4:0]        MEM_WB_rd,
  output logic              MEM_WB_RegWrite,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_stall,
  output logic [CNT_W-1:0]  stall_cnt
);
  typedef enum logic {M_IDLE, M_WAIT} state_t;
  state_t state_q, state_d;
  logic em_valid_q, em_rw_q, em_mr_q, em_mw_q;
  logic [4:0] em_rd_q;
  logic [1:0] em_src_q;
  logic [DATA_W-1:0] em_alu_q, em_sd_q, em_imm_q, em_pc4_q;
  logic wb_rw_q;
  logic [4:0] wb_rd_q;
  logic [1:0] wb_src_q;
  logic [DATA_W-1:0] wb_alu_q, wb_ld_q, wb_imm_q, wb_pc4_q;
  logic [CNT_W-1:0] cnt_q;
  logic mem_op, em_valid_d, em_rw_d;
  assign mem_op     = em_valid_q & (em_mr_q | em_mw_q);
  assign mem_stall  = mem_op & ~dmem_ack;
  assign em_valid_d = ex_valid & ~flush_ex;
  // RegWrite is pre-gated: invalid, store (incl. read+write) and rd==0 never write
  assign em_rw_d    = em_valid_d & ex_reg_write & ~ex_mem_write & (ex_rd != 5'd0);
  always_comb begin
    state_d  = state_q;
    dmem_req = mem_op | (state_q == M_WAIT);
    if (state_q == M_IDLE) state_d = (mem_op & ~dmem_ack) ? M_WAIT : M_IDLE;
    else state_d = dmem_ack ? M_IDLE : M_WAIT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= M_IDLE;
    else state_q <= state_d;
  // EX/MEM holds while stalled, so the request fields stay stable through M_WAIT
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      em_valid_q <= 1'b0;
      em_rw_q    <= 1'b0;
      em_mr_q    <= 1'b0;
      em_mw_q    <= 1'b0;
      em_rd_q    <= '0;
      em_src_q   <= '0;
      em_alu_q   <= '0;
      em_sd_q    <= '0;
      em_imm_q   <= '0;
      em_pc4_q   <= '0;
    end else if (!mem_stall) begin
      em_valid_q <= em_valid_d;
      em_rw_q    <= em_rw_d;
      em_mr_q    <= ex_mem_read;
      em_mw_q    <= ex_mem_write;
      em_rd_q    <= ex_rd;
      em_src_q   <= ex_write_src;
      em_alu_q   <= ex_alu_out;
      em_sd_q    <= ex_store_data;
      em_imm_q   <= ex_imm_op;
      em_pc4_q   <= ex_pc_plus4;
    end
  // A stall cycle pushes a bubble into MEM/WB by clearing RegWrite only
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wb_rw_q  <= 1'b0;
      wb_rd_q  <= '0;
      wb_src_q <= '0;
      wb_alu_q <= '0;
      wb_ld_q  <= '0;
      wb_imm_q <= '0;
      wb_pc4_q <= '0;
      cnt_q    <= '0;
    end else begin
      wb_rw_q <= em_rw_q & ~mem_stall;
      if (!mem_stall) begin
        wb_rd_q  <= em_rd_q;
        wb_src_q <= em_src_q;
        wb_alu_q <= em_alu_q;
        wb_imm_q <= em_imm_q;
        wb_pc4_q <= em_pc4_q;
      end
      if (dmem_ack) wb_ld_q <= dmem_rdata;
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, mem_stall & ~&cnt_q};
    end
  assign dmem_we         = mem_op & em_mw_q;
  assign dmem_addr       = em_alu_q[ADDR_W-1:0];
  assign dmem_wdata      = em_sd_q;
  assign EX_MEM_rd       = em_rd_q;
  assign EX_MEM_RegWrite = em_rw_q;
  assign EX_MEM_WriteSrc = em_src_q;
  assign EX_MEM_AluOut   = em_alu_q;
  assign EX_MEM_ImmOp    = em_imm_q;
  assign MEM_WB_rd       = wb_rd_q;
  assign MEM_WB_RegWrite = wb_rw_q;
  assign wb_data         = wb_src_q[1] ? (wb_src_q[0] ? wb_imm_q : wb_pc4_q)
                                       : (wb_src_q[0] ? wb_ld_q : wb_alu_q);
  assign stall_cnt       = cnt_q;
endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: directed and randomized self-checking bench for mem_wb_pipe
module tb_mem_wb_pipe;
  logic clk = 1'b0;
  logic rst_n, ex_valid, flush_ex, ex_reg_write, ex_mem_read, ex_mem_write, dmem_ack;
  logic [4:0] ex_rd;
  logic [1:0] ex_write_src;
  logic [31:0] ex_alu_out, ex_store_data, ex_imm_op, ex_pc_plus4, dmem_rdata;
  logic dmem_req, dmem_we, EX_MEM_RegWrite, MEM_WB_RegWrite, mem_stall;
  logic [31:0] dmem_addr, dmem_wdata, EX_MEM_AluOut, EX_MEM_ImmOp, wb_data;
  logic [4:0] EX_MEM_rd, MEM_WB_rd;
  logic [1:0] EX_MEM_WriteSrc;
  logic [15:0] stall_cnt;
  int checks = 0;
  int errors = 0;
  typedef struct packed {logic v, fl, rw, mr, mw; logic [4:0] rd; logic [1:0] src; logic [31:0] alu, sd, imm, pc4;} instr_t;
  typedef struct packed {logic [4:0] rd; logic [31:0] d;} wb_t;
  typedef struct packed {logic we; logic [31:0] a, w;} mo_t;
  wb_t wb_q[$];
  mo_t mo_q[$];
  logic [31:0] ref_mem[8];
  logic [31:0] resp_mem[8];
  mem_wb_pipe dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .flush_ex(flush_ex), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_write_src(ex_write_src), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
    .ex_imm_op(ex_imm_op), .ex_pc_plus4(ex_pc_plus4), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_WriteSrc(EX_MEM_WriteSrc),
    .EX_MEM_AluOut(EX_MEM_AluOut), .EX_MEM_ImmOp(EX_MEM_ImmOp), .MEM_WB_rd(MEM_WB_rd),
    .MEM_WB_RegWrite(MEM_WB_RegWrite), .wb_data(wb_data), .mem_stall(mem_stall), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_ex(input logic v, input logic [4:0] rd, input logic rw, input logic [1:0] src,
                        input logic mr, input logic mw, input logic [31:0] alu, input logic [31:0] sd);
    ex_valid = v; ex_rd = rd; ex_reg_write = rw; ex_write_src = src;
    ex_mem_read = mr; ex_mem_write = mw; ex_alu_out = alu; ex_store_data = sd;
    ex_imm_op = 32'h0; ex_pc_plus4 = 32'h0; flush_ex = 1'b0;
  endtask
  function automatic instr_t rnd_instr();
    instr_t i;
    int k;
    k = $urandom_range(0, 7);
    i.v = ($urandom_range(0, 9) != 0);
    i.fl = ($urandom_range(0, 7) == 0);
    i.rw = ($urandom_range(0, 3) != 0);
    i.rd = 5'($urandom);
    i.src = 2'($urandom);
    i.alu = {25'($urandom), 3'($urandom), 2'b00};
    i.sd = $urandom; i.imm = $urandom; i.pc4 = $urandom;
    i.mr = 1'b0; i.mw = 1'b0;
    if (k < 2) begin i.mr = 1'b1; i.src = 2'b01; end
    else if (k < 4) i.mw = 1'b1;
    else if (k == 4) begin i.mr = 1'b1; i.mw = 1'b1; end
    else if (i.src == 2'b01) i.src = 2'b00;
    return i;
  endfunction
  initial begin
    instr_t cur;
    wb_t w;
    mo_t m;
    logic pending, busy, ack, exp_stall;
    logic [31:0] req_addr, val;
    int lat, waited, n_stall;
    rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    // reset state
    repeat (2) tick();
    chk("rst_req", {31'b0, dmem_req}, 0);
    chk("rst_stall", {31'b0, mem_stall}, 0);
    chk("rst_exrw", {31'b0, EX_MEM_RegWrite}, 0);
    chk("rst_wbrw", {31'b0, MEM_WB_RegWrite}, 0);
    chk("rst_wbdata", wb_data, 0);
    chk("rst_cnt", {16'b0, stall_cnt}, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    // ALU op
    set_ex(1, 5, 1, 2'b00, 0, 0, 32'h10, 0);
    tick();
    chk("alu_exrd", {27'b0, EX_MEM_rd}, 5);
    chk("alu_exrw", {31'b0, EX_MEM_RegWrite}, 1);
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("alu_wbrw", {31'b0, MEM_WB_RegWrite}, 1);
    chk("alu_wbrd", {27'b0, MEM_WB_rd}, 5);
    chk("alu_wbdata", wb_data, 32'h10);
    // load, zero-latency ack
    set_ex(1, 6, 1, 2'b01, 1, 0, 32'h100, 0);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    chk("ld0_req", {31'b0, dmem_req}, 1);
    chk("ld0_we", {31'b0, dmem_we}, 0);
    chk("ld0_addr", dmem_addr, 32'h100);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1 chk("ld0_stall", {31'b0, mem_stall}, 0);
    tick();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    chk("ld0_wbrw", {31'b0, MEM_WB_RegWrite}, 1);
    chk("ld0_wbdata", wb_data, 32'hDEADBEEF);
    // load, ack 3 cycles late; next instruction waits upstream with flush_ex toggled
    set_ex(1, 8, 1, 2'b01, 1, 0, 32'h200, 0);
    tick();
    set_ex(1, 9, 1, 2'b00, 0, 0, 32'h55, 0);
    for (int i = 0; i < 3; i++) begin
      flush_ex = 1'b1;
      dmem_rdata = 32'hBAD0_0000 + 32'(i);
      #1 chk("ld3_stall", {31'b0, mem_stall}, 1);
      chk("ld3_req", {31'b0, dmem_req}, 1);
      chk("ld3_addr", dmem_addr, 32'h200);
      chk("ld3_exrd", {27'b0, EX_MEM_rd}, 8);
      tick();
      chk("ld3_bubble", {31'b0, MEM_WB_RegWrite}, 0);
    end
    flush_ex = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    #1 chk("ld3_ackstall", {31'b0, mem_stall}, 0);
    tick();
    dmem_ack = 1'b0;
    chk("ld3_cnt", {16'b0, stall_cnt}, 3);
    chk("ld3_wbdata", wb_data, 32'hCAFEF00D);
    chk("ld3_wbrd", {27'b0, MEM_WB_rd}, 8);
    chk("flstall_exrd", {27'b0, EX_MEM_rd}, 9);
    chk("flstall_exrw", {31'b0, EX_MEM_RegWrite}, 1);
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("flstall_wbdata", wb_data, 32'h55);
    chk("flstall_wbrw", {31'b0, MEM_WB_RegWrite}, 1);
    // store with reg_write set
    set_ex(1, 7, 1, 2'b00, 0, 1, 32'h300, 32'h1234);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    chk("st_req", {31'b0, dmem_req}, 1);
    chk("st_we", {31'b0, dmem_we}, 1);
    chk("st_wdata", dmem_wdata, 32'h1234);
    chk("st_exrw", {31'b0, EX_MEM_RegWrite}, 0);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("st_wbrw", {31'b0, MEM_WB_RegWrite}, 0);
    // flushed load
    set_ex(1, 10, 1, 2'b01, 1, 0, 32'h400, 0);
    flush_ex = 1'b1;
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    chk("fl_exrw", {31'b0, EX_MEM_RegWrite}, 0);
    chk("fl_req", {31'b0, dmem_req}, 0);
    chk("fl_stall", {31'b0, mem_stall}, 0);
    // reset while waiting on memory
    set_ex(1, 11, 1, 2'b01, 1, 0, 32'h400, 0);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("rw_req_pre", {31'b0, dmem_req}, 1);
    #2 rst_n = 1'b0;
    #1 chk("rw_req", {31'b0, dmem_req}, 0);
    chk("rw_stall", {31'b0, mem_stall}, 0);
    chk("rw_exrw", {31'b0, EX_MEM_RegWrite}, 0);
    chk("rw_wbrw", {31'b0, MEM_WB_RegWrite}, 0);
    chk("rw_cnt", {16'b0, stall_cnt}, 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    // randomized traffic against an in-order reference of writebacks and memory accesses
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = 32'h1111_1111 * 32'(i);
      resp_mem[i] = ref_mem[i];
    end
    pending = 1'b0; busy = 1'b0; lat = 0; waited = 0; n_stall = 0; req_addr = 32'h0;
    for (int c = 0; c < 700; c++) begin
      if (!pending) begin
        cur = rnd_instr();
        if (c >= 680) cur.v = 1'b0;
        pending = 1'b1;
      end
      ex_valid = cur.v; ex_rd = cur.rd; ex_reg_write = cur.rw; ex_write_src = cur.src;
      ex_mem_read = cur.mr; ex_mem_write = cur.mw; ex_alu_out = cur.alu;
      ex_store_data = cur.sd; ex_imm_op = cur.imm; ex_pc_plus4 = cur.pc4;
      if (MEM_WB_RegWrite) begin
        if (wb_q.size() == 0) chk("wb_extra", 1, 0);
        else begin
          w = wb_q.pop_front();
          chk("wb_rd", {27'b0, MEM_WB_rd}, {27'b0, w.rd});
          chk("wb_data", wb_data, w.d);
        end
      end
      ack = 1'b0;
      if (dmem_req) begin
        if (!busy) begin
          busy = 1'b1; waited = 0; lat = $urandom_range(0, 3); req_addr = dmem_addr;
          if (mo_q.size() == 0) chk("req_extra", 1, 0);
          else begin
            m = mo_q.pop_front();
            chk("req_we", {31'b0, dmem_we}, {31'b0, m.we});
            chk("req_addr", dmem_addr, m.a);
            if (m.we) chk("req_wdata", dmem_wdata, m.w);
          end
        end else chk("addr_hold", dmem_addr, req_addr);
        ack = (waited == lat);
      end
      dmem_ack = ack;
      dmem_rdata = (ack && !dmem_we) ? resp_mem[dmem_addr[4:2]] : $urandom;
      if (ack && dmem_we) resp_mem[dmem_addr[4:2]] = dmem_wdata;
      exp_stall = busy && !ack;
      flush_ex = exp_stall ? ($urandom_range(0, 1) == 1) : cur.fl;
      #1 chk("stall", {31'b0, mem_stall}, {31'b0, exp_stall});
      if (exp_stall) begin waited++; n_stall++; end
      if (ack) busy = 1'b0;
      if (!exp_stall) begin
        pending = 1'b0;
        if (cur.v && !cur.fl) begin
          if (cur.mr || cur.mw) mo_q.push_back('{we: cur.mw, a: cur.alu, w: cur.sd});
          if (cur.mw) ref_mem[cur.alu[4:2]] = cur.sd;
          else if (cur.rw && cur.rd != 5'd0) begin
            case (cur.src)
              2'b00: val = cur.alu;
              2'b01: val = ref_mem[cur.alu[4:2]];
              2'b10: val = cur.pc4;
              default: val = cur.imm;
            endcase
            wb_q.push_back('{rd: cur.rd, d: val});
          end
        end
      end
      tick();
    end
    chk("wb_pending", wb_q.size(), 0);
    chk("mo_pending", mo_q.size(), 0);
    chk("rnd_cnt", {16'b0, stall_cnt}, n_stall);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
